// File: rtl/version_store_pkg.sv
// Shared types and sizing helpers for the versioned data store controller.
package version_store_pkg;

  typedef enum logic {IDLE, ROUTE} state_t;

  function automatic int slot_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int version_mod(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/version_match.sv
// Combinational lookup: is key present in any valid slot?
module version_match #(
  parameter int NUM_SLOTS = 4,
  parameter int VER_W     = 4
) (
  input  logic [NUM_SLOTS-1:0]            valid,
  input  logic [NUM_SLOTS-1:0][VER_W-1:0] versions,
  input  logic [VER_W-1:0]                key,
  output logic                            hit
);

  logic [NUM_SLOTS-1:0] lane_hit;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    assign lane_hit[i] = valid[i] && (versions[i] == key);
  end

  assign hit = |lane_hit;

endmodule

// File: rtl/version_store_ctrl.sv
// Round-robin multi-version store feeding an external priority router;
// sequences each read through the router and registers data plus hit flag.
module version_store_ctrl
  import version_store_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int VERSION_WIDTH = 4,
  parameter int VERSION_NUM   = 4
) (
  input  logic                               clk,
  input  logic                               rstN,
  input  logic                               flush,
  input  logic                               wrValid,
  input  logic [DATA_WIDTH-1:0]              wrData,
  output logic                               wrReady,
  output logic [VERSION_WIDTH-1:0]           wrVersion,
  input  logic                               rdValid,
  input  logic [VERSION_WIDTH-1:0]           rdVersion,
  output logic                               rdReady,
  output logic                               rdDataValid,
  output logic [DATA_WIDTH-1:0]              rdData,
  output logic                               rdHit,
  output logic [VERSION_NUM-1:0]             slotValid,
  output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
  output logic [DATA_WIDTH*VERSION_NUM-1:0]  dataInputs,
  output logic [VERSION_WIDTH-1:0]           routerReadVersion,
  input  logic [DATA_WIDTH-1:0]              routerDataOut
);

  localparam int PW = slot_idx_w(VERSION_NUM);
  localparam logic [PW-1:0] LAST_SLOT = PW'(VERSION_NUM - 1);

  if (VERSION_NUM < 2 || VERSION_NUM > version_mod(VERSION_WIDTH)) begin : g_param_chk
    $error("VERSION_NUM must be in [2, 2**VERSION_WIDTH]");
  end

  state_t                                      state;
  logic [PW-1:0]                               wr_ptr;
  logic [VERSION_WIDTH-1:0]                    next_ver;
  logic                                        hit_req;
  logic [VERSION_NUM-1:0][VERSION_WIDTH-1:0]   ver_q;
  logic [VERSION_NUM-1:0][DATA_WIDTH-1:0]      data_q;
  logic [VERSION_NUM-1:0][VERSION_WIDTH-1:0]   eff_ver;
  logic [VERSION_NUM-1:0]                      eff_vld;
  logic                                        wr_acc;
  logic                                        hit_now;

  assign wrReady    = (state == IDLE) && !flush;
  assign rdReady    = (state == IDLE) && !flush;
  assign wrVersion  = next_ver;
  assign versions   = ver_q;
  assign dataInputs = data_q;
  assign wr_acc     = wrValid && wrReady;

  // A read accepted alongside a write must see that write, so the hit
  // lookup runs on the store as it will look after this edge.
  always_comb begin
    eff_ver = ver_q;
    eff_vld = slotValid;
    if (wr_acc) begin
      eff_ver[wr_ptr] = next_ver;
      eff_vld[wr_ptr] = 1'b1;
    end
  end

  version_match #(
    .NUM_SLOTS (VERSION_NUM),
    .VER_W     (VERSION_WIDTH)
  ) u_match (
    .valid    (eff_vld),
    .versions (eff_ver),
    .key      (rdVersion),
    .hit      (hit_now)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      next_ver          <= '0;
      hit_req           <= 1'b0;
      slotValid         <= '0;
      ver_q             <= '0;
      data_q            <= '0;
      routerReadVersion <= '0;
      rdData            <= '0;
      rdHit             <= 1'b0;
      rdDataValid       <= 1'b0;
    end else begin
      rdDataValid <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        wr_ptr    <= '0;
        next_ver  <= '0;
        hit_req   <= 1'b0;
        slotValid <= '0;
        ver_q     <= '0;
        data_q    <= '0;
      end else begin
        if (wr_acc) begin
          data_q[wr_ptr]    <= wrData;
          ver_q[wr_ptr]     <= next_ver;
          slotValid[wr_ptr] <= 1'b1;
          wr_ptr            <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
          next_ver          <= next_ver + 1'b1;
        end
        case (state)
          IDLE: if (rdValid) begin
            state             <= ROUTE;
            routerReadVersion <= rdVersion;
            hit_req           <= hit_now;
          end
          // Invalid slots can alias in the router; only hit_req decides.
          ROUTE: begin
            state       <= IDLE;
            rdData      <= hit_req ? routerDataOut : '0;
            rdHit       <= hit_req;
            rdDataValid <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_version_store_ctrl.sv
// Directed bench for version_store_ctrl with a behavioural priority router.
module tb_version_store_ctrl;

  localparam int DW = 32;
  localparam int VW = 4;
  localparam int VN = 4;

  logic            clk = 1'b0;
  logic            rstN = 1'b0;
  logic            flush = 1'b0;
  logic            wrValid = 1'b0;
  logic [DW-1:0]   wrData = '0;
  logic            wrReady;
  logic [VW-1:0]   wrVersion;
  logic            rdValid = 1'b0;
  logic [VW-1:0]   rdVersion = '0;
  logic            rdReady;
  logic            rdDataValid;
  logic [DW-1:0]   rdData;
  logic            rdHit;
  logic [VN-1:0]   slotValid;
  logic [VW*VN-1:0] versions;
  logic [DW*VN-1:0] dataInputs;
  logic [VW-1:0]   routerReadVersion;
  logic [DW-1:0]   routerDataOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  version_store_ctrl #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN)) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .wrValid(wrValid), .wrData(wrData), .wrReady(wrReady), .wrVersion(wrVersion),
    .rdValid(rdValid), .rdVersion(rdVersion), .rdReady(rdReady),
    .rdDataValid(rdDataValid), .rdData(rdData), .rdHit(rdHit),
    .slotValid(slotValid), .versions(versions), .dataInputs(dataInputs),
    .routerReadVersion(routerReadVersion), .routerDataOut(routerDataOut)
  );

  // External router stand-in: lowest-index slot with matching version wins.
  always_comb begin
    routerDataOut = '0;
    for (int i = VN - 1; i >= 0; i--)
      if (versions[i*VW +: VW] == routerReadVersion) routerDataOut = dataInputs[i*DW +: DW];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [DW-1:0] d);
    wrValid = 1'b1;
    wrData  = d;
    tick();
    wrValid = 1'b0;
  endtask

  task automatic read(input logic [VW-1:0] v, input logic exp_hit, input logic [DW-1:0] exp_data);
    rdValid   = 1'b1;
    rdVersion = v;
    tick();
    rdValid = 1'b0;
    chk("rd_no_early_pulse", rdDataValid, 1'b0);
    chk("rd_busy", rdReady, 1'b0);
    tick();
    chk("rd_pulse", rdDataValid, 1'b1);
    chk("rd_hit", rdHit, exp_hit);
    chk("rd_data", rdData, exp_data);
    tick();
    chk("rd_pulse_one_cycle", rdDataValid, 1'b0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    chk("flush_wr_ready", wrReady, 1'b0);
    chk("flush_rd_ready", rdReady, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush_slot_valid", slotValid, '0);
    chk("flush_wr_version", wrVersion, '0);
  endtask

  initial begin
    #12;
    chk("rst_slot_valid", slotValid, '0);
    chk("rst_wr_ready", wrReady, 1'b1);
    chk("rst_rd_ready", rdReady, 1'b1);
    chk("rst_wr_version", wrVersion, '0);
    chk("rst_rd_data_valid", rdDataValid, 1'b0);
    rstN = 1'b1;
    tick();

    // Empty store: version 0 must not alias onto invalid slots
    read(4'd0, 1'b0, 32'h0);

    for (int i = 0; i < 3; i++) begin
      chk("wr_version_seq", wrVersion, 64'(i));
      write(32'h11 * (i + 1));
    end
    chk("three_writes_valid", slotValid, 4'b0111);
    read(4'd1, 1'b1, 32'h22);

    do_flush();
    for (int i = 0; i < 6; i++) write(32'hA0 + i);
    chk("evict_versions", versions, 16'h3254);
    chk("evict_valid", slotValid, 4'b1111);
    read(4'd0, 1'b0, 32'h0);
    read(4'd5, 1'b1, 32'hA5);
    read(4'd2, 1'b1, 32'hA2);

    do_flush();
    for (int i = 0; i < 18; i++) begin
      if (i == 16) chk("wrap_to_zero", wrVersion, 4'd0);
      write(32'hB0 + i);
    end
    chk("wrap_next", wrVersion, 4'd2);
    read(4'd14, 1'b1, 32'hBE);
    read(4'd15, 1'b1, 32'hBF);
    read(4'd0, 1'b1, 32'hC0);
    read(4'd1, 1'b1, 32'hC1);
    read(4'd13, 1'b0, 32'h0);

    // Same-cycle write and read of the version being written
    chk("raw_wr_version", wrVersion, 4'd2);
    wrValid = 1'b1; wrData = 32'h55;
    rdValid = 1'b1; rdVersion = 4'd2;
    tick();
    wrValid = 1'b0; rdValid = 1'b0;
    chk("raw_route_wr_ready", wrReady, 1'b0);
    tick();
    chk("raw_pulse", rdDataValid, 1'b1);
    chk("raw_hit", rdHit, 1'b1);
    chk("raw_data", rdData, 32'h55);
    tick();

    // Write held through ROUTE stalls, then lands
    rdValid = 1'b1; rdVersion = 4'd3;
    tick();
    rdValid = 1'b0;
    wrValid = 1'b1; wrData = 32'h66;
    #1;
    chk("stall_wr_ready", wrReady, 1'b0);
    tick();
    chk("stall_rd_pulse", rdDataValid, 1'b1);
    chk("stall_rd_hit", rdHit, 1'b0);
    chk("stall_rd_data", rdData, 32'h0);
    chk("stall_wr_ready_back", wrReady, 1'b1);
    chk("stall_wr_version", wrVersion, 4'd3);
    tick();
    wrValid = 1'b0;
    chk("stall_accepted_version", wrVersion, 4'd4);
    chk("stall_versions", versions, 16'h3210);
    read(4'd3, 1'b1, 32'h66);

    // Flush while a read is in ROUTE
    rdValid = 1'b1; rdVersion = 4'd3;
    tick();
    rdValid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_abort_pulse", rdDataValid, 1'b0);
    chk("flush_abort_valid", slotValid, '0);
    chk("flush_abort_version", wrVersion, '0);
    chk("flush_abort_data", dataInputs, '0);
    tick();
    chk("flush_abort_no_late_pulse", rdDataValid, 1'b0);

    // Async reset while a write lands and a read is in flight
    wrValid = 1'b1; wrData = 32'h77;
    rdValid = 1'b1; rdVersion = 4'd0;
    tick();
    rdValid = 1'b0;
    wrData = 32'h88;
    chk("pre_rst_valid", slotValid, 4'b0001);
    #2 rstN = 1'b0;
    #1;
    chk("arst_slot_valid", slotValid, '0);
    chk("arst_wr_version", wrVersion, '0);
    chk("arst_versions", versions, '0);
    chk("arst_data", dataInputs, '0);
    chk("arst_rd_data_valid", rdDataValid, 1'b0);
    chk("arst_wr_ready", wrReady, 1'b1);
    chk("arst_rd_ready", rdReady, 1'b1);
    chk("arst_router_rv", routerReadVersion, '0);
    wrValid = 1'b0;
    rstN = 1'b1;
    tick();
    chk("arst_no_pulse", rdDataValid, 1'b0);
    chk("arst_no_write", slotValid, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
